// File: rtl/mem_bus_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the shared core memory bus.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready per requester, mem_req held until mem_ack.
interface mem_bus_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int N_REQ = 2
);
  // requester side
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*XLEN-1:0]     req_addr;
  logic [N_REQ*XLEN/8-1:0]   req_byteen;
  logic [N_REQ-1:0]          req_we;
  logic [N_REQ*XLEN-1:0]     req_wdata;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          rsp_valid;
  logic [XLEN-1:0]           rsp_rdata;
  logic                      rsp_err;
  // memory side
  logic [XLEN-1:0]           mem_addr;
  logic [XLEN/8-1:0]         mem_byteen;
  logic                      mem_we;
  logic [XLEN-1:0]           mem_wdata;
  logic                      mem_req;
  logic [XLEN-1:0]           mem_rdata;
  logic                      mem_ack;
  logic                      mem_err;

  // arbiter view: masters the memory bus, answers the requesters
  modport master (
    input  req_valid, req_addr, req_byteen, req_we, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_byteen, mem_we, mem_wdata, mem_req,
    input  mem_rdata, mem_ack, mem_err
  );

  // environment view: requesters plus memory slave
  modport slave (
    output req_valid, req_addr, req_byteen, req_we, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_byteen, mem_we, mem_wdata, mem_req,
    output mem_rdata, mem_ack, mem_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among N_REQ requesters, one transaction in flight.
// Latency: accept edge -> mem_req next cycle; mem_ack at cycle k -> rsp_valid pulse at k+1.
// Backpressure: req_ready only in IDLE with clk_en; a silent slave is cut off by a timeout error.
module mem_bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  mem_bus_arbiter_if.master  bus,
  output logic               busy
);
  localparam int BW = XLEN / 8;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [PW-1:0] LAST_PORT = PW'(N_REQ - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   cur_idx;
  logic            gnt_found;
  logic            accept;
  logic            timed_out;
  logic [TW-1:0]   timer;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [BW-1:0]   lat_byteen;
  logic            lat_we;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;

  // per-port views of the flattened request buses
  logic [XLEN-1:0] addr_arr   [N_REQ];
  logic [XLEN-1:0] wdata_arr  [N_REQ];
  logic [BW-1:0]   byteen_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]   = bus.req_addr[i*XLEN +: XLEN];
    assign wdata_arr[i]  = bus.req_wdata[i*XLEN +: XLEN];
    assign byteen_arr[i] = bus.req_byteen[i*BW +: BW];
  end

  // pick the first valid port at or after rr_ptr, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && clk_en && gnt_found;
  assign timed_out = clk_en && (timer == TIMER_MAX);

  // one-hot ready for the winner and one-hot response pulse for the owner
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = accept && (gnt_idx == PW'(i));
      bus.rsp_valid[i] = (state == RESP) && (cur_idx == PW'(i));
    end
  end

  assign bus.mem_req    = (state == BUSY);
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_byteen = lat_byteen;
  assign bus.mem_we     = lat_we;
  assign bus.mem_wdata  = lat_wdata;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != IDLE);

  // transaction FSM with round-robin pointer and clk_en-gated watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      timer   <= '0;
      cur_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_idx <= gnt_idx;
            rr_ptr  <= (gnt_idx == LAST_PORT) ? '0 : gnt_idx + 1'b1;
            timer   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // ack is honoured even on disabled cycles and beats a same-cycle timeout
          if (bus.mem_ack || timed_out) begin
            state <= RESP;
          end else if (clk_en) begin
            timer <= timer + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // latch the granted request and capture the response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_byteen  <= '0;
      lat_we      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr   <= addr_arr[gnt_idx];
        lat_wdata  <= wdata_arr[gnt_idx];
        lat_byteen <= byteen_arr[gnt_idx];
        lat_we     <= bus.req_we[gnt_idx];
      end
      if (state == BUSY) begin
        if (bus.mem_ack) begin
          rsp_rdata_q <= bus.mem_rdata;
          rsp_err_q   <= bus.mem_err;
        end else if (timed_out) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
    end
  end
endmodule
